// File: rtl/shader_pkg.sv
// Shared opcodes, FSM states and instruction field positions for shader_core.
package shader_pkg;

  localparam logic [4:0] OP_NOP     = 5'd0;
  localparam logic [4:0] OP_ADD     = 5'd1;
  localparam logic [4:0] OP_SUB     = 5'd2;
  localparam logic [4:0] OP_LD      = 5'd3;
  localparam logic [4:0] OP_ST      = 5'd5;
  localparam logic [4:0] OP_SETP    = 5'd8;
  localparam logic [4:0] OP_LI      = 5'd12;
  localparam logic [4:0] OP_BRA     = 5'd13;
  localparam logic [4:0] OP_STOREQI = 5'd15;
  localparam logic [4:0] OP_END     = 5'd16;

  localparam int GUARD_LSB = 30;
  localparam int OPC_LSB   = 24;
  localparam int OPC_W     = 5;
  localparam int RS0_LSB   = 20;
  localparam int RS1_LSB   = 16;
  localparam int RD_LSB    = 12;
  localparam int IMM12_W   = 12;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    LD_WAIT
  } state_e;

  typedef struct packed {
    logic add;
    logic sub;
    logic ld;
    logic st;
    logic setp;
    logic li;
    logic bra;
    logic storeq;
    logic end_op;
  } dec_t;

endpackage

// File: rtl/shader_decode.sv
// Combinational instruction decode: opcode flags, guard evaluation and field slices.
module shader_decode
  import shader_pkg::*;
#(
  parameter int RW = 4,
  parameter int PW = 2,
  parameter int QW = 4
) (
  input  logic [31:0]   instr_i,
  input  logic          pred_val_i,
  output dec_t          dec_o,
  output logic          guard_ok_o,
  output logic [RW-1:0] rs0_o,
  output logic [RW-1:0] rs1_o,
  output logic [RW-1:0] rd_o,
  output logic [PW-1:0] pred_o,
  output logic [PW-1:0] pd_o,
  output logic [QW-1:0] qn_o,
  output logic [11:0]   imm12_o,
  output logic [15:0]   imm16_o
);

  logic [OPC_W-1:0] opcode;
  logic             unused_bit;

  assign opcode     = instr_i[OPC_LSB +: OPC_W];
  assign unused_bit = instr_i[29];

  assign rs0_o   = instr_i[RS0_LSB +: RW];
  assign rs1_o   = instr_i[RS1_LSB +: RW];
  assign rd_o    = instr_i[RD_LSB +: RW];
  assign pd_o    = instr_i[RD_LSB +: PW];
  assign qn_o    = instr_i[RD_LSB +: QW];
  assign pred_o  = instr_i[GUARD_LSB +: PW];
  assign imm12_o = instr_i[IMM12_W-1:0];
  assign imm16_o = {instr_i[19:16], instr_i[IMM12_W-1:0]};

  // Predicate 0 is hard-wired true; the external value is not consulted.
  assign guard_ok_o = (pred_o == '0) || pred_val_i;

  // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_o = '0;
    case (opcode)
      OP_ADD:     dec_o.add    = 1'b1;
      OP_SUB:     dec_o.sub    = 1'b1;
      OP_LD:      dec_o.ld     = 1'b1;
      OP_ST:      dec_o.st     = 1'b1;
      OP_SETP:    dec_o.setp   = 1'b1;
      OP_LI:      dec_o.li     = 1'b1;
      OP_BRA:     dec_o.bra    = 1'b1;
      OP_STOREQI: dec_o.storeq = 1'b1;
      OP_END:     dec_o.end_op = 1'b1;
      default:    dec_o        = '0;
    endcase
  end

endmodule

// File: rtl/shader_core.sv
// In-order shader micro-core: fetch/execute FSM around shader_decode.
// Optional relative branch on opcode 13 when SHADER_CORE_BRANCH_EN is defined.
module shader_core
  import shader_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int NPRED  = 4,
  parameter int ADDR_W = 16,
  parameter int NQ     = 16,
  localparam int RW    = $clog2(NREG),
  localparam int PW    = $clog2(NPRED),
  localparam int QW    = $clog2(NQ)
) (
  input  logic              clk,
  input  logic              rst,
  output logic [PC_W-1:0]   curr_pc,
  input  logic [31:0]       instr,
  output logic [RW-1:0]     readreg0,
  output logic [RW-1:0]     readreg1,
  input  logic [DATA_W-1:0] in_reg0,
  input  logic [DATA_W-1:0] in_reg1,
  output logic              reg_wen,
  output logic [RW-1:0]     reg_waddr,
  output logic [DATA_W-1:0] reg_wval,
  output logic [PW-1:0]     pred,
  input  logic              pred_val,
  output logic              pred_wen,
  output logic [PW-1:0]     pred_waddr,
  output logic              pred_wval,
  output logic [ADDR_W-1:0] readmem0,
  input  logic [DATA_W-1:0] in_mem0,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wval,
  output logic              queue_valid,
  input  logic              queue_ready,
  output logic [QW-1:0]     queue_number,
  output logic [DATA_W-1:0] queue_wval,
  output logic              request_new_pc,
  input  logic              set_pc,
  input  logic [PC_W-1:0]   new_pc,
  output logic              busy
);

  state_e          state_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [RW-1:0]   ld_rd_q;

  dec_t            dec;
  logic            guard_ok;
  logic [RW-1:0]   rs0, rs1, rd;
  logic [PW-1:0]   pd;
  logic [QW-1:0]   qn;
  logic [11:0]     imm12;
  logic [15:0]     imm16;

  logic [DATA_W-1:0] addr_sum;
  logic [ADDR_W-1:0] addr;
  logic              q_stall;
  logic              unused_sum;

  shader_decode #(.RW(RW), .PW(PW), .QW(QW)) u_decode (
    .instr_i    (instr),
    .pred_val_i (pred_val),
    .dec_o      (dec),
    .guard_ok_o (guard_ok),
    .rs0_o      (rs0),
    .rs1_o      (rs1),
    .rd_o       (rd),
    .pred_o     (pred),
    .pd_o       (pd),
    .qn_o       (qn),
    .imm12_o    (imm12),
    .imm16_o    (imm16)
  );

  assign curr_pc        = pc_q;
  assign readreg0       = rs0;
  assign readreg1       = rs1;
  assign busy           = (state_q != IDLE);
  assign request_new_pc = (state_q == IDLE);

  assign addr_sum   = in_reg0 + DATA_W'(imm12);
  assign addr       = addr_sum[ADDR_W-1:0];
  assign unused_sum = ^addr_sum[DATA_W-1:ADDR_W];

  // A pushing STOREQI freezes pc and instr until the queue accepts.
  assign q_stall = guard_ok && dec.storeq && !queue_ready;

  always_comb begin
    reg_wen      = 1'b0;
    reg_waddr    = '0;
    reg_wval     = '0;
    pred_wen     = 1'b0;
    pred_waddr   = '0;
    pred_wval    = 1'b0;
    mem_wen      = 1'b0;
    mem_waddr    = '0;
    mem_wval     = '0;
    readmem0     = '0;
    queue_valid  = 1'b0;
    queue_number = '0;
    queue_wval   = '0;
    pc_d         = pc_q + PC_W'(1);

    if (state_q == LD_WAIT) begin
      reg_wen   = 1'b1;
      reg_waddr = ld_rd_q;
      reg_wval  = in_mem0;
    end else if (state_q == EXEC && guard_ok) begin
      if (dec.add || dec.sub || dec.li) begin
        reg_wen   = 1'b1;
        reg_waddr = rd;
        if (dec.add)      reg_wval = in_reg0 + in_reg1;
        else if (dec.sub) reg_wval = in_reg0 - in_reg1;
        else              reg_wval = DATA_W'(imm16);
      end
      if (dec.ld) readmem0 = addr;
      if (dec.st) begin
        mem_wen   = 1'b1;
        mem_waddr = addr;
        mem_wval  = in_reg1;
      end
      if (dec.setp) begin
        pred_wen   = 1'b1;
        pred_waddr = pd;
        pred_wval  = (in_reg0 < in_reg1);
      end
      if (dec.storeq) begin
        queue_valid  = 1'b1;
        queue_number = qn;
        queue_wval   = in_reg0;
      end
`ifdef SHADER_CORE_BRANCH_EN
      if (dec.bra) pc_d = pc_q + {{(PC_W-12){imm12[11]}}, imm12};
`endif
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ld_rd_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (set_pc) begin
            pc_q    <= new_pc;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          if (dec.end_op) begin
            state_q <= IDLE;
          end else if (guard_ok && dec.ld) begin
            ld_rd_q <= rd;
            state_q <= LD_WAIT;
          end else if (!q_stall) begin
            pc_q <= pc_d;
          end
        end
        LD_WAIT: begin
          pc_q    <= pc_d;
          state_q <= EXEC;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
